imm_encoder: RTL
================

# imm_encoder

Streaming immediate encoder: the producing side of the 8-bit immediate / sign-extend-enable pair consumed by the decode-stage sign extender. Accepts a 16-bit constant and emits the shortest sequence of 8-bit immediate beats that reconstruct it exactly. One-beat encodings carry the extension mode the consumer must apply. Constants that do not fit in 8 bits are split into a high beat and a low beat. Sits between the instruction/constant builder and the instruction-word packer.

## Interface
- CNT_W, 16, width of the statistics counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  constant available
- in_ready  out  1  encoder accepts constant this cycle
- in_value  in  16  constant to encode
- in_signed  in  1  1 = sign-extended encoding permitted; 0 = zero-extend only
- out_valid  out  1  beat available
- out_ready  in  1  consumer takes beat this cycle
- out_imm  out  8  immediate byte
- out_sext  out  1  extension mode for this beat (sign_extend_en to consumer)
- out_hi  out  1  beat is the high byte of a split pair
- out_last  out  1  final beat of the current constant
- fit_count  out  CNT_W  constants encoded in one beat
- split_count  out  CNT_W  constants encoded in two beats

## Operation
- Transfer on input when in_valid && in_ready. Transfer on output when out_valid && out_ready.
- Classification of accepted value V, in priority order:
  - ZFIT: V[15:8]==0. One beat: imm=V[7:0], sext=0, hi=0, last=1. Applies in both modes.
  - SFIT: in_signed=1 and V[15:7] all ones. One beat: imm=V[7:0], sext=1, hi=0, last=1.
  - SPLIT: everything else. Beat 0: imm=V[15:8], sext=0, hi=1, last=0. Beat 1: imm=V[7:0], sext=0, hi=0, last=1. Consumer rebuilds the constant as {hi_byte, lo_byte}.
- Unsigned mode with V in 0xFF80..0xFFFF encodes as SPLIT, never SFIT.
- FSM states:
  - IDLE: no beat held.
  - ONE: single beat held.
  - HI: high beat held, low byte stored internally.
  - LO: low beat held.
- Transitions:
  - IDLE -> ONE or HI on accept.
  - ONE -> IDLE on output transfer with no accept; ONE -> ONE/HI on output transfer with simultaneous accept.
  - HI -> LO on output transfer.
  - LO behaves as ONE.
- in_ready = (state==IDLE) || ((state==ONE || state==LO) && out_ready). in_ready is never high in HI.
- Output fields are held stable while out_valid && !out_ready.
- Counters:
  - fit_count increments on accept of ZFIT/SFIT; split_count increments on accept of SPLIT.
  - Both saturate at all-ones with no wrap.
  - Counters count accepted constants, not emitted beats.

## Timing
- Reset: state=IDLE; out_valid=0, out_imm=0, out_sext=0, out_hi=0, out_last=0; fit_count=0, split_count=0; in_ready=1 in the first cycle after reset.
- Latency: first beat valid the cycle after accept. Beats are registered; there is no combinational in->out path.
- Throughput: one constant per cycle for fitting values with out_ready held high. SPLIT constants take 2 cycles each.
- Reset mid-operation (in HI or LO) drops the pending beats; counters clear.
- in_value and in_signed are sampled only at accept. Changes while in_ready=0 have no effect.

## Structure
- Shared package `imm_pkg`:
  - state enum IDLE/ONE/HI/LO
  - IMM_W=8 and CONST_W=16
  - classification enum ZFIT/SFIT/SPLIT
- One natural sub-module, `imm_classify`: combinational, takes value and signed mode, returns class. Reused by the assembler-side checker.
- Top block holds the FSM, the output register, the stored low byte and the counters.

## Test plan
- Fitting constants, in_signed=1, out_ready=1: V=0x0042, then 0xFFF0, then 0x007F back-to-back -> three single beats on consecutive cycles: (0x42,sext0), (0xF0,sext1), (0x7F,sext0), all last=1; fit_count=3.
- V=0x1234, in_signed=1 -> beats (0x12,hi1,last0) then (0x34,hi0,last1); in_ready low for one cycle; split_count=1.
- V=0xFF80 with in_signed=0 -> split into 0xFF, 0x80. Same value with in_signed=1 -> single beat 0x80, sext=1.
- Backpressure: out_ready=0 for 5 cycles during beat 0 of 0xABCD -> out_imm holds 0xAB and out_hi holds 1, no new accept; release -> 0xCD follows.
- Assert rst while in LO -> next cycle out_valid=0, counters=0, in_ready=1.
- Saturation with CNT_W=4: 20 fitting constants -> fit_count stays 0xF.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate encoder: beat widths, FSM states and
// the constant classification used by both encoder and assembler checker.
package imm_pkg;

    localparam int IMM_W   = 8;
    localparam int CONST_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ONE,
        HI,
        LO
    } state_t;

    typedef enum logic [1:0] {
        ZFIT,
        SFIT,
        SPLIT
    } imm_class_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational classifier: decides whether a 16-bit constant fits one
// zero-extended beat, one sign-extended beat, or needs a high/low split.
module imm_classify
    import imm_pkg::*;
(
    input  logic [CONST_W-1:0] value,
    input  logic               signed_mode,
    output imm_class_t         cls
);

    // Zero-extension wins over sign-extension so 0x0000..0x00FF never carry sext.
    always_comb begin
        cls = SPLIT;
        if (value[CONST_W-1:IMM_W] == '0) begin
            cls = ZFIT;
        end else if (signed_mode && (&value[CONST_W-1:IMM_W-1])) begin
            cls = SFIT;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: turns one 16-bit constant into one or two
// registered 8-bit beats and keeps saturating fit/split statistics.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CONST_W-1:0] in_value,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_sext,
    output logic               out_hi,
    output logic               out_last,
    output logic [CNT_W-1:0]   fit_count,
    output logic [CNT_W-1:0]   split_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    imm_class_t       cls;
    logic [IMM_W-1:0] lo_byte;
    logic             accept;

    imm_classify u_classify (
        .value       (in_value),
        .signed_mode (in_signed),
        .cls         (cls)
    );

    // A new constant may replace a final beat only in the cycle that beat leaves.
    assign in_ready  = (state == IDLE) || (((state == ONE) || (state == LO)) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_imm     <= '0;
            out_sext    <= 1'b0;
            out_hi      <= 1'b0;
            out_last    <= 1'b0;
            lo_byte     <= '0;
            fit_count   <= '0;
            split_count <= '0;
        end else if (accept) begin
            if (cls == SPLIT) begin
                state    <= HI;
                out_imm  <= in_value[CONST_W-1:IMM_W];
                out_sext <= 1'b0;
                out_hi   <= 1'b1;
                out_last <= 1'b0;
                lo_byte  <= in_value[IMM_W-1:0];
                if (split_count != '1) begin
                    split_count <= split_count + CNT_ONE;
                end
            end else begin
                state    <= ONE;
                out_imm  <= in_value[IMM_W-1:0];
                out_sext <= (cls == SFIT);
                out_hi   <= 1'b0;
                out_last <= 1'b1;
                if (fit_count != '1) begin
                    fit_count <= fit_count + CNT_ONE;
                end
            end
        end else if (out_ready) begin
            case (state)
                HI: begin
                    state    <= LO;
                    out_imm  <= lo_byte;
                    out_sext <= 1'b0;
                    out_hi   <= 1'b0;
                    out_last <= 1'b1;
                end
                ONE, LO: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
